// File: rtl/slice_sub.sv
`default_nettype none
// ============================================================================
// Module   : slice_sub
// Brief    : Serial subtractor, a - b - bin, one SLICE-bit slice per clock,
//            with a registered borrow rippling LSB slice to MSB slice.
// Revision : 1.0 - initial release
// ============================================================================
module slice_sub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] c_last_idx = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic [SLICE-1:0] w_a_k;
    logic [SLICE-1:0] w_b_k;
    logic [SLICE:0]   w_sub;

    // One extra bit on the slice difference captures the borrow out.
    always_comb begin
        w_a_k = r_a[int'(r_idx)*SLICE +: SLICE];
        w_b_k = r_b[int'(r_idx)*SLICE +: SLICE];
        w_sub = {1'b0, w_a_k} - {1'b0, w_b_k} - {{SLICE{1'b0}}, r_borrow};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_borrow  <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_idx    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    diff[int'(r_idx)*SLICE +: SLICE] <= w_sub[SLICE-1:0];
                    r_borrow <= w_sub[SLICE];
                    r_idx    <= r_idx + IW'(1);
                    // The top slice supplies the result sign used for overflow.
                    if (r_idx == c_last_idx) begin
                        bout      <= w_sub[SLICE];
                        overflow  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                                     (w_sub[SLICE-1] ^ r_a[WIDTH-1]);
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/slice_sub.md
Name: slice_sub

Overview:
- Multi-cycle subtractor that computes a - b - bin over WIDTH-bit operands, one SLICE-bit slice per clock, LSB slice first.
- A registered borrow ripples between slices; the borrow logic is the subtract-side counterpart of the team's registered carry-lookahead adder.
- Sits in the ALU datapath where area matters more than latency.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 16: operand and result width; must be an integer multiple of SLICE.
- SLICE, 4: bits processed per cycle.
- N (derived, localparam) = WIDTH/SLICE: number of compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  unsigned borrow out: 1 iff a < b + bin
- overflow  output  1  two's-complement overflow of the subtraction

Behaviour:
- While rst=0, all registers clear immediately, independent of clk:
  - state = IDLE, slice index = 0, borrow = 0, diff = 0, bout = 0, overflow = 0, out_valid = 0.
  - in_ready = 1.
- The state machine is IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On a clk edge with in_valid=1: latch a and b into operand registers, borrow <= bin, index <= 0, go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each cycle, for slice k = index: {borrow_next, d_k} = a_k - b_k - borrow, where a_k = a_reg[k*SLICE +: SLICE].
  - Write d_k into diff[k*SLICE +: SLICE]; borrow <= borrow_next; index <= index + 1.
  - After slice N-1 is processed: bout <= final borrow, compute overflow, go to DONE.
- Latency: out_valid rises exactly N clk edges after the accept edge (4 edges with default parameters).
- overflow = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]), evaluated on the completed result.
- DONE:
  - out_valid = 1, in_ready = 0.
  - diff, bout and overflow are held stable.
  - On a clk edge with out_ready=1: go to IDLE, out_valid falls the next cycle. diff/bout/overflow keep their last values until the next operation overwrites them.
- No bypass: a new operand is never accepted in the same cycle a result is consumed; in_ready rises only once the block is back in IDLE.
- Inputs a, b, bin and in_valid are ignored in BUSY and DONE. Operands are used only from the latched registers.
- out_ready is ignored outside DONE.
- Slice index wrap-around is never reached; the index is cleared on every accept.
- With N=1 (WIDTH=SLICE), BUSY lasts a single cycle.
- Reset asserted mid-operation (BUSY or DONE) aborts the operation. All outputs return to their reset values, and no partial result is presented afterwards.
- Arithmetic is unsigned within each slice. Per-slice widths are SLICE+1 bits to capture the borrow.

Test Plan:
- a=0x1234, b=0x0234, bin=0, out_ready=1 -> out_valid high 4 edges after accept, diff=0x1000, bout=0, overflow=0; in_ready low for exactly 5 cycles.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, overflow=0. Then a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, overflow=0.
- Signed overflow cases:
  - a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, overflow=1.
  - a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE -> out_valid and diff stay constant and in_ready stays 0.
  - Drive in_valid=1 with different operands during BUSY -> they are ignored and the original result is unchanged.
  - Raise out_ready -> IDLE one edge later.
- Reset: drop rst to 0 two cycles into BUSY (between clock edges) -> outputs clear immediately with no clk edge. After release, in_ready=1 and out_valid=0. A new operation a=0x0010, b=0x0001 completes with diff=0x000F.
- Back-to-back: issue 20 random operand pairs with random out_ready stalls -> every result matches a reference model of (a - b - bin) mod 2^16 with borrow and overflow, and no result is dropped or duplicated.
